// File: rtl/decode_regfile_stage.sv
// RV32I decode stage: register file (2R/1W, optional write-to-read bypass), immediate generator,
// and one registered decode/execute slot with valid/ready handshake, stall-time operand refresh and flush.
module decode_regfile_stage #(
  parameter int  XLEN   = 32,
  parameter int  NREGS  = 32,
  parameter bit  BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [AW-1:0]   out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [AW-1:0]   rs1_idx_q, rs1_idx_d;
  logic [AW-1:0]   rs2_idx_q, rs2_idx_d;

  logic [AW-1:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]    rs1_val, rs2_val;
  logic signed [31:0] imm32;
  logic               wb_hit, accept, hold;

  // Register index fields are truncated to AW bits; higher index bits are ignored.
  assign rs1_idx = inst[15 +: AW];
  assign rs2_idx = inst[20 +: AW];
  assign rd_idx  = inst[7 +: AW];

  assign wb_hit   = wb_en && (wb_rd != '0);
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign hold     = out_valid_q && !out_ready;

  always_comb begin
    rs1_val = regs_q[rs1_idx];
    rs2_val = regs_q[rs2_idx];
    if (BYPASS && wb_hit && (wb_rd == rs1_idx)) rs1_val = wb_data;
    if (BYPASS && wb_hit && (wb_rd == rs2_idx)) rs2_val = wb_data;
    if (rs1_idx == '0) rs1_val = '0;
    if (rs2_idx == '0) rs2_val = '0;
  end

  // Immediates are formed at 32 bits and then sign-extended to XLEN by the signed size cast.
  always_comb begin
    unique case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {inst[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a signal unassigned (no latches).
    regs_d         = regs_q;
    out_inst_d     = out_inst_q;
    out_pc_d       = out_pc_q;
    out_rd_d       = out_rd_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_imm_d      = out_imm_q;
    rs1_idx_d      = rs1_idx_q;
    rs2_idx_d      = rs2_idx_q;

    if (wb_hit) regs_d[wb_rd] = wb_data;

    if (accept) begin
      out_inst_d     = inst;
      out_pc_d       = in_pc;
      out_rd_d       = rd_idx;
      out_rs1_data_d = rs1_val;
      out_rs2_data_d = rs2_val;
      out_imm_d      = XLEN'(imm32);
      rs1_idx_d      = rs1_idx;
      rs2_idx_d      = rs2_idx;
    end else if (hold) begin
      // A held operand must not go stale while execute is stalled, whatever BYPASS says.
      if (wb_hit && (wb_rd == rs1_idx_q)) out_rs1_data_d = wb_data;
      if (wb_hit && (wb_rd == rs2_idx_q)) out_rs2_data_d = wb_data;
    end

    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is reset too, so every register reads 0 after reset, not just x0.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out_valid_q    <= 1'b0;
      out_inst_q     <= '0;
      out_pc_q       <= '0;
      out_rd_q       <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_imm_q      <= '0;
      rs1_idx_q      <= '0;
      rs2_idx_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      regs_q         <= regs_d;
      out_valid_q    <= out_valid_d;
      out_inst_q     <= out_inst_d;
      out_pc_q       <= out_pc_d;
      out_rd_q       <= out_rd_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_imm_q      <= out_imm_d;
      rs1_idx_q      <= rs1_idx_d;
      rs2_idx_q      <= rs2_idx_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign out_rd       = out_rd_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_imm      = out_imm_q;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Bench for decode_regfile_stage: directed scenarios plus randomized traffic checked against a
// behavioural model (register array + one-slot pipeline) derived from the stage's rules.
module tb_decode_regfile_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk, rst;
  logic            in_valid, in_ready, nb_in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] in_pc;
  logic            flush, wb_en, out_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, nb_out_valid;
  logic [31:0]     out_inst, nb_out_inst;
  logic [XLEN-1:0] out_pc, nb_out_pc;
  logic [AW-1:0]   out_rd, nb_out_rd;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data, out_imm;
  logic [XLEN-1:0] nb_out_rs1_data, nb_out_rs2_data, nb_out_imm;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state (model uses BYPASS=1, matching u_dut).
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_inst, m_pc, m_rs1, m_rs2;

  decode_regfile_stage #(.XLEN(XLEN), .NREGS(32), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_rd(out_rd),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm)
  );

  decode_regfile_stage #(.XLEN(XLEN), .NREGS(32), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .inst(inst), .in_pc(in_pc),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(nb_out_valid),
    .out_ready(out_ready), .out_inst(nb_out_inst), .out_pc(nb_out_pc), .out_rd(nb_out_rd),
    .out_rs1_data(nb_out_rs1_data), .out_rs2_data(nb_out_rs2_data), .out_imm(nb_out_imm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] hi;
    hi = i[31] ? 32'hFFFF_FFFF : 32'h0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: return (hi << 12) | (i >> 20);
      7'h23: return (hi << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
      7'h63: return (hi << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
                    | (((i >> 8) & 32'hF) << 1);
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return (hi << 20) | (i & 32'h000F_F000) | (((i >> 20) & 32'h1) << 11)
                    | (((i >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0;
    m_inst  = 32'h0;
    m_pc    = 32'h0;
    m_rs1   = 32'h0;
    m_rs2   = 32'h0;
  endtask

  task automatic drive_idle();
    in_valid  = 1'b0;
    inst      = 32'h0000_0013;
    in_pc     = 32'h0;
    flush     = 1'b0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    out_ready = 1'b1;
  endtask

  // Advance the model by one clock edge using the current inputs, then step the DUT past the edge.
  task automatic tick();
    logic rdy, acc, hold;
    rdy  = !flush && (!m_valid || out_ready);
    acc  = in_valid && rdy;
    hold = m_valid && !out_ready;
    if (acc) begin
      m_inst = inst;
      m_pc   = in_pc;
      m_rs1  = ref_read(inst[19:15]);
      m_rs2  = ref_read(inst[24:20]);
    end else if (hold && wb_en && wb_rd != 5'd0) begin
      if (wb_rd == m_inst[19:15]) m_rs1 = wb_data;
      if (wb_rd == m_inst[24:20]) m_rs2 = wb_data;
    end
    m_valid = flush ? 1'b0 : (acc ? 1'b1 : (m_valid && !out_ready));
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", out_pc); end
    // Load x5 and hold an instruction, then reset mid-stall.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA_5555;
    in_valid = 1'b1; inst = 32'h0002_8313; in_pc = 32'h40; out_ready = 1'b0;
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_held got=%0h exp=1", out_valid); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid got=%0h exp=0", out_valid); end
    checks++; if (out_rs1_data !== 32'h0) begin failures++; $display("FAIL reset_async_rs1 got=%0h exp=0", out_rs1_data); end
    model_reset();
    #1 rst = 1'b0;
    in_valid = 1'b1; inst = 32'h0002_8313; in_pc = 32'h44; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_rs1_data !== 32'h0) begin failures++; $display("FAIL reset_x5_cleared got=%0h exp=0", out_rs1_data); end
  endtask

  task automatic test_basic();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; inst = 32'hFFF2_8313; in_pc = 32'h200;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency got=%0h exp=0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", out_valid); end
    checks++; if (out_rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_rs1 got=%0h exp=deadbeef", out_rs1_data); end
    checks++; if (out_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL basic_imm got=%0h exp=ffffffff", out_imm); end
    checks++; if (out_rd !== 5'd6) begin failures++; $display("FAIL basic_rd got=%0h exp=6", out_rd); end
    checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL basic_pc got=%0h exp=200", out_pc); end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h77; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    wb_data = 32'h1234; in_valid = 1'b1; inst = 32'h0003_8093; in_pc = 32'h300;
    tick();
    checks++; if (out_rs1_data !== 32'h1234) begin failures++; $display("FAIL bypass_on got=%0h exp=1234", out_rs1_data); end
    checks++; if (nb_out_rs1_data !== 32'h77) begin failures++; $display("FAIL bypass_off got=%0h exp=77", nb_out_rs1_data); end
    wb_rd = 5'd0; wb_data = 32'hFFFF; inst = 32'h0000_0093; in_pc = 32'h304;
    tick();
    checks++; if (out_rs1_data !== 32'h0) begin failures++; $display("FAIL bypass_x0 got=%0h exp=0", out_rs1_data); end
    checks++; if (nb_out_rs1_data !== 32'h0) begin failures++; $display("FAIL bypass_x0_nb got=%0h exp=0", nb_out_rs1_data); end
    wb_en = 1'b0; inst = 32'h0003_8093; in_pc = 32'h308;
    tick();
    in_valid = 1'b0;
    checks++; if (nb_out_rs1_data !== 32'h1234) begin failures++; $display("FAIL bypass_written got=%0h exp=1234", nb_out_rs1_data); end
  endtask

  task automatic test_imm();
    logic [31:0] ins [6];
    logic [31:0] exp [6];
    ins = '{32'hFE00_0EE3, 32'h1234_50B7, 32'hFF9F_F06F, 32'h0000_000B, 32'hFE11_2E23, 32'h0000_1017};
    exp = '{32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_1000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; inst = ins[i]; in_pc = 32'h400 + 32'(i * 4);
      tick();
      checks++;
      if (out_imm !== exp[i]) begin
        failures++; $display("FAIL imm_%0d inst=%08h got=%08h exp=%08h", i, ins[i], out_imm, exp[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h0002_8313; in_pc = 32'h500;
    tick();
    out_ready = 1'b0; inst = 32'h0000_0013; in_pc = 32'h504;
    for (int c = 0; c < 3; c++) begin
      wb_en = (c == 1); wb_rd = 5'd5; wb_data = 32'h55;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_%0d got=%0h exp=0", c, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_inst !== 32'h0002_8313) begin
        failures++; $display("FAIL stall_stable_%0d valid=%0h pc=%0h inst=%0h exp=1/500/00028313", c, out_valid, out_pc, out_inst);
      end
      if (c == 1) begin
        checks++; if (out_rs1_data !== 32'h55) begin failures++; $display("FAIL stall_refresh got=%0h exp=55", out_rs1_data); end
        checks++; if (nb_out_rs1_data !== 32'h55) begin failures++; $display("FAIL stall_refresh_nb got=%0h exp=55", nb_out_rs1_data); end
      end
    end
    wb_en = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%0h exp=1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h504) begin
      failures++; $display("FAIL stall_replace valid=%0h pc=%0h exp=1/504", out_valid, out_pc);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1; inst = 32'h0001_8093; in_pc = 32'h600;
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h9;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_rs1_data !== 32'h9) begin
      failures++; $display("FAIL flush_after valid=%0h pc=%0h rs1=%0h exp=1/600/9", out_valid, out_pc, out_rs1_data);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; inst = 32'h0000_0013 | (32'(i) << 20); in_pc = 32'h700 + 32'(i * 4);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== (32'h700 + 32'(i * 4)) || out_imm !== 32'(i)) begin
        failures++; $display("FAIL b2b_%0d valid=%0h pc=%0h imm=%0h", i, out_valid, out_pc, out_imm);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] iv;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
    for (int c = 0; c < 400; c++) begin
      iv = $urandom();
      iv[6:0] = ops[$urandom_range(0, 10)];
      in_valid  = ($urandom_range(0, 3) != 0);
      inst      = iv;
      in_pc     = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = AW'($urandom_range(0, 31));
      wb_data   = $urandom();
      #1;
      checks++;
      if (in_ready !== (!flush && (!m_valid || out_ready))) begin
        failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0h exp=%0h", c, in_ready, !flush && (!m_valid || out_ready));
      end
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0h", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (out_inst !== m_inst || out_pc !== m_pc || out_rd !== m_inst[11:7]) begin
          failures++; $display("FAIL rnd_slot cyc=%0d inst=%0h/%0h pc=%0h/%0h rd=%0h/%0h", c,
                               out_inst, m_inst, out_pc, m_pc, out_rd, m_inst[11:7]);
        end
        checks++;
        if (out_rs1_data !== m_rs1 || out_rs2_data !== m_rs2) begin
          failures++; $display("FAIL rnd_operands cyc=%0d rs1=%0h/%0h rs2=%0h/%0h", c,
                               out_rs1_data, m_rs1, out_rs2_data, m_rs2);
        end
        checks++;
        if (out_imm !== ref_imm(m_inst)) begin
          failures++; $display("FAIL rnd_imm cyc=%0d inst=%0h got=%0h exp=%0h", c, m_inst, out_imm, ref_imm(m_inst));
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    drive_idle();
    model_reset();
    #12 rst = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_imm();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
